// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: registered next-PC selector for the Fetch stage.
//
// The block chooses one of NUM_SRC candidate addresses by fixed priority and
// registers the choice as the fetch PC. Source 0 is the sequential source.
// Sources 1..NUM_SRC-1 are redirects, and a higher index has higher priority.
// While stall is high the PC holds. The highest-priority redirect that
// arrives during the stall is kept in a one-entry pending buffer, so that
// redirect is not lost.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   src_data   in   packed candidates; source i at [i*WIDTH +: WIDTH]
//   src_valid  in   per-source request
//   stall      in   freeze PC, buffer redirects
//   pc_q       out  registered fetch PC
//   pc_valid   out  pc_q is fetchable this cycle
//   sel_idx    out  source index that produced pc_q
//   redirect   out  one-cycle pulse on a load from index >= 1 or from pending
//   pend_valid out  a redirect is buffered
module fetch_pc_sel #(
  parameter int               WIDTH    = 32,
  parameter int               NUM_SRC  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic                       stall,
  output logic [WIDTH-1:0]           pc_q,
  output logic                       pc_valid,
  output logic [SEL_W-1:0]           sel_idx,
  output logic                       redirect,
  output logic                       pend_valid
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic [SEL_W-1:0] sel_idx_q, sel_idx_d;
  logic             redirect_q, redirect_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [SEL_W-1:0] pend_idx_q, pend_idx_d;

  logic [WIDTH-1:0] src_word_s [NUM_SRC];
  logic             new_any_s;
  logic [SEL_W-1:0] new_idx_s;

  // Unpack the candidate bus into one word per source.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_word_s[g] = src_data[g*WIDTH +: WIDTH];
  end

  // Find the winning redirect. The last valid index wins, so the
  // highest valid index >= 1 is selected.
  always_comb begin
    new_any_s = 1'b0;
    new_idx_s = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        new_any_s = 1'b1;
        new_idx_s = SEL_W'(i);
      end else begin
        new_any_s = new_any_s;
      end
    end
  end

  // Compute the next state, the next PC, and the pending buffer contents.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    sel_idx_d    = sel_idx_q;
    redirect_d   = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_idx_d   = pend_idx_q;
    case (state_q)
      ST_BOOT: begin
        // The first edge out of reset publishes RESET_PC. All inputs are
        // ignored on this edge, stall included.
        pc_valid_d = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          // Equal priority overwrites the buffer, so the newest redirect wins.
          if (new_any_s && (!pend_valid_q || (new_idx_s >= pend_idx_q))) begin
            pend_valid_d = 1'b1;
            pend_data_d  = src_word_s[new_idx_s];
            pend_idx_d   = new_idx_s;
          end else begin
            pend_valid_d = pend_valid_q;
          end
        end else if (pend_valid_q && (!new_any_s || (pend_idx_q > new_idx_s))) begin
          pc_d         = pend_data_q;
          sel_idx_d    = pend_idx_q;
          pc_valid_d   = 1'b1;
          redirect_d   = 1'b1;
          pend_valid_d = 1'b0;
        end else if (new_any_s) begin
          pc_d         = src_word_s[new_idx_s];
          sel_idx_d    = new_idx_s;
          pc_valid_d   = 1'b1;
          redirect_d   = 1'b1;
          pend_valid_d = 1'b0;
        end else if (src_valid[0]) begin
          pc_d         = src_word_s[0];
          sel_idx_d    = '0;
          pc_valid_d   = 1'b1;
          redirect_d   = 1'b0;
          pend_valid_d = 1'b0;
        end else begin
          // Bubble: the PC holds but cannot be fetched this cycle.
          pc_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  // Register all state. Reset is synchronous and active-low, and it
  // discards any pending redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      sel_idx_q    <= '0;
      redirect_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      sel_idx_q    <= sel_idx_d;
      redirect_q   <= redirect_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_idx_q   <= pend_idx_d;
    end
  end

  assign pc_valid   = pc_valid_q;
  assign sel_idx    = sel_idx_q;
  assign redirect   = redirect_q;
  assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_fetch_pc_sel.sv
// Directed testbench for fetch_pc_sel (WIDTH=32, NUM_SRC=4).
module tb_fetch_pc_sel;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         stall;
  logic [31:0]  pc_q;
  logic         pc_valid;
  logic [1:0]   sel_idx;
  logic         redirect;
  logic         pend_valid;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_sel #(.WIDTH(32), .NUM_SRC(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .stall(stall), .pc_q(pc_q), .pc_valid(pc_valid), .sel_idx(sel_idx),
    .redirect(redirect), .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [31:0] val);
    src_data[idx*32 +: 32] = val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; src_valid = 4'b0000; src_data = '0;
    step();
    step();
    n_tests++; if (pc_q !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc_q, 32'h0); end
    n_tests++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pcv: got %b want 0", pc_valid); end
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redir: got %b want 0", redirect); end
    n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", pend_valid); end
    n_tests++; if (sel_idx !== 2'd0) begin n_fail++; $display("FAIL rst_sel: got %0d want 0", sel_idx); end
    rst_n = 1'b1;
    step();
    n_tests++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL boot_pcv: got %b want 1", pc_valid); end
    n_tests++; if (pc_q !== 32'h0) begin n_fail++; $display("FAIL boot_pc: got %h want 0", pc_q); end
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL boot_redir: got %b want 0", redirect); end
  endtask

  task automatic test_seq_priority();
    set_src(0, 32'h0000_0004); src_valid = 4'b0001;
    step();
    n_tests++; if (pc_q !== 32'h0000_0004) begin n_fail++; $display("FAIL seq_pc: got %h want %h", pc_q, 32'h4); end
    n_tests++; if (sel_idx !== 2'd0) begin n_fail++; $display("FAIL seq_sel: got %0d want 0", sel_idx); end
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL seq_redir: got %b want 0", redirect); end
    set_src(0, 32'h0000_0008); set_src(1, 32'h0000_0100); set_src(3, 32'hDEAD_BEEF);
    src_valid = 4'b1011;
    step();
    n_tests++; if (pc_q !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_pc: got %h want %h", pc_q, 32'hDEADBEEF); end
    n_tests++; if (sel_idx !== 2'd3) begin n_fail++; $display("FAIL prio_sel: got %0d want 3", sel_idx); end
    n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL prio_redir: got %b want 1", redirect); end
    set_src(0, 32'hDEAD_BEF3); src_valid = 4'b0001;
    step();
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL prio_pulse: got %b want 0", redirect); end
    n_tests++; if (pc_q !== 32'hDEAD_BEF3) begin n_fail++; $display("FAIL seq2_pc: got %h want %h", pc_q, 32'hDEADBEF3); end
  endtask

  task automatic test_stall_buffer();
    stall = 1'b1; set_src(2, 32'hCAFE_BABE); src_valid = 4'b0100;
    step();
    n_tests++; if (pc_q !== 32'hDEAD_BEF3) begin n_fail++; $display("FAIL stall_pc: got %h want %h", pc_q, 32'hDEADBEF3); end
    n_tests++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pend: got %b want 1", pend_valid); end
    n_tests++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL stall_pcv: got %b want 1", pc_valid); end
    // src1 is lower priority than the buffered src2. src0 is ignored during the stall.
    set_src(1, 32'h1234_5678); set_src(0, 32'h0000_0010); src_valid = 4'b0011;
    step();
    n_tests++; if (pc_q !== 32'hDEAD_BEF3) begin n_fail++; $display("FAIL stall2_pc: got %h want %h", pc_q, 32'hDEADBEF3); end
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL stall2_redir: got %b want 0", redirect); end
    stall = 1'b0; src_valid = 4'b0000;
    step();
    n_tests++; if (pc_q !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL rel_pc: got %h want %h", pc_q, 32'hCAFEBABE); end
    n_tests++; if (sel_idx !== 2'd2) begin n_fail++; $display("FAIL rel_sel: got %0d want 2", sel_idx); end
    n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL rel_redir: got %b want 1", redirect); end
    n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL rel_pend: got %b want 0", pend_valid); end
  endtask

  task automatic test_bubble();
    stall = 1'b0; src_valid = 4'b0000;
    step();
    n_tests++; if (pc_q !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL bub_pc: got %h want %h", pc_q, 32'hCAFEBABE); end
    n_tests++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL bub_pcv: got %b want 0", pc_valid); end
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bub_redir: got %b want 0", redirect); end
    n_tests++; if (sel_idx !== 2'd2) begin n_fail++; $display("FAIL bub_sel: got %0d want 2", sel_idx); end
  endtask

  task automatic test_release_race();
    stall = 1'b1; set_src(1, 32'h0000_0040); src_valid = 4'b0010;
    step();
    n_tests++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL race_pend: got %b want 1", pend_valid); end
    stall = 1'b0; set_src(3, 32'h0000_0800); src_valid = 4'b1000;
    step();
    n_tests++; if (pc_q !== 32'h0000_0800) begin n_fail++; $display("FAIL race_pc: got %h want %h", pc_q, 32'h800); end
    n_tests++; if (sel_idx !== 2'd3) begin n_fail++; $display("FAIL race_sel: got %0d want 3", sel_idx); end
    n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL race_pend2: got %b want 0", pend_valid); end
    src_valid = 4'b0000;
    step();
    n_tests++; if (pc_q !== 32'h0000_0800) begin n_fail++; $display("FAIL race_drop: got %h want %h", pc_q, 32'h800); end
  endtask

  task automatic test_pend_priority();
    // With equal priority, the newest redirect overwrites the buffer.
    stall = 1'b1; set_src(2, 32'h0000_00A1); src_valid = 4'b0100;
    step();
    set_src(2, 32'h0000_00A2);
    step();
    stall = 1'b0; src_valid = 4'b0000;
    step();
    n_tests++; if (pc_q !== 32'h0000_00A2) begin n_fail++; $display("FAIL eq_pc: got %h want %h", pc_q, 32'hA2); end
    // A pending src3 beats a new src1 on the release edge.
    stall = 1'b1; set_src(3, 32'h0000_0C00); src_valid = 4'b1000;
    step();
    stall = 1'b0; set_src(1, 32'h0000_0111); src_valid = 4'b0010;
    step();
    n_tests++; if (pc_q !== 32'h0000_0C00) begin n_fail++; $display("FAIL pendwin_pc: got %h want %h", pc_q, 32'hC00); end
    n_tests++; if (sel_idx !== 2'd3) begin n_fail++; $display("FAIL pendwin_sel: got %0d want 3", sel_idx); end
    // src1 is still valid, so it loads on the next edge.
    step();
    n_tests++; if (pc_q !== 32'h0000_0111) begin n_fail++; $display("FAIL after_pc: got %h want %h", pc_q, 32'h111); end
    src_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1; set_src(2, 32'h0000_0055); src_valid = 4'b0100;
    step();
    n_tests++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL rms_pend: got %b want 1", pend_valid); end
    rst_n = 1'b0; src_valid = 4'b0000;
    step();
    n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL rms_pend2: got %b want 0", pend_valid); end
    n_tests++; if (pc_q !== 32'h0) begin n_fail++; $display("FAIL rms_pc: got %h want 0", pc_q); end
    n_tests++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL rms_pcv: got %b want 0", pc_valid); end
    // Stall stays high through boot, where it is ignored.
    rst_n = 1'b1;
    step();
    n_tests++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL rms_boot: got %b want 1", pc_valid); end
    stall = 1'b0;
    step();
    n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rms_replay: got %b want 0", redirect); end
    n_tests++; if (pc_q !== 32'h0) begin n_fail++; $display("FAIL rms_pc2: got %h want 0", pc_q); end
    n_tests++; if (sel_idx !== 2'd0) begin n_fail++; $display("FAIL rms_sel: got %0d want 0", sel_idx); end
  endtask

  initial begin
    test_reset();
    test_seq_priority();
    test_stall_buffer();
    test_bubble();
    test_release_race();
    test_pend_priority();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
